// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS receive decoder: control tokens,
// symbol/byte widths and the word-alignment FSM states.
package tmds_pkg;

  localparam int SYM_W  = 10;
  localparam int BYTE_W = 8;

  localparam logic [SYM_W-1:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } align_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: recognises the four control tokens and
// undoes the transition-minimising / DC-balancing encode for data symbols.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0]  sym,
  output logic [BYTE_W-1:0] data,
  output logic [1:0]        ctrl,
  output logic              is_token
);

  logic [BYTE_W-1:0] q;

  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    case (sym)
      TOKEN_C00: ctrl = 2'b00;
      TOKEN_C01: ctrl = 2'b01;
      TOKEN_C10: ctrl = 2'b10;
      TOKEN_C11: ctrl = 2'b11;
      default:   is_token = 1'b0;
    endcase
  end

  // bit 9 flags an inverted payload, bit 8 selects XOR vs XNOR chaining
  always_comb begin
    q       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = q[0];
    for (int i = 1; i < BYTE_W; i++) begin
      data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: bit-slip word alignment on control tokens, then a
// two-stage decode pipeline. Define TMDS_DEC_ERR_EN to add a loss-of-lock counter.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int HUNT_LEN     = 64,
  parameter int LOCK_RUN     = 8,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [SYM_W-1:0]  raw_in,
  output logic [BYTE_W-1:0] data_out,
  output logic [1:0]        ctrl_out,
  output logic              de_out,
  output logic              valid_out,
  output logic              locked_out,
  output logic [3:0]        offset_out
`ifdef TMDS_DEC_ERR_EN
  ,
  output logic [7:0]        err_count_out
`endif
);

  localparam int DWELL_W = $clog2(HUNT_LEN + 1);
  localparam int RUN_W   = $clog2(LOCK_RUN + 1);
  localparam int LOSS_W  = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HUNT_LEN - 1);
  localparam logic [RUN_W-1:0]   RUN_DONE   = RUN_W'(LOCK_RUN);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_TIMEOUT - 1);

  align_state_t        state, state_n;
  logic [3:0]          offset, offset_n, offset_adv;
  logic [DWELL_W-1:0]  dwell, dwell_n;
  logic [RUN_W-1:0]    run, run_n, run_inc;
  logic [LOSS_W-1:0]   loss, loss_n;

  logic [SYM_W-1:0]    prev_raw;
  logic [2*SYM_W-1:0]  window;
  logic [SYM_W-1:0]    aligned;
  logic [BYTE_W-1:0]   dec_data;
  logic [1:0]          dec_ctrl;
  logic                dec_token;

  logic                tok_s1, lock_s1;
  logic [BYTE_W-1:0]   data_s1;
  logic [1:0]          ctrl_s1;

  assign window  = {raw_in, prev_raw};
  assign aligned = window[{1'b0, offset} +: SYM_W];

  tmds_symbol_decode u_decode (
    .sym      (aligned),
    .data     (dec_data),
    .ctrl     (dec_ctrl),
    .is_token (dec_token)
  );

  assign offset_adv = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  assign run_inc    = (run == RUN_DONE) ? run : run + RUN_W'(1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= HUNT;
      offset   <= '0;
      dwell    <= '0;
      run      <= '0;
      loss     <= '0;
      prev_raw <= '0;
    end else begin
      state    <= state_n;
      offset   <= offset_n;
      dwell    <= dwell_n;
      run      <= run_n;
      loss     <= loss_n;
      prev_raw <= raw_in;
    end
  end

  // Dwell and loss counters never pass their terminal values, so they cannot wrap.
  always_comb begin
    state_n  = state;
    offset_n = offset;
    dwell_n  = dwell;
    run_n    = run;
    loss_n   = loss;
    case (state)
      HUNT: begin
        if (dec_token) begin
          state_n = VERIFY;
          run_n   = RUN_W'(1);
          dwell_n = '0;
        end else if (dwell == DWELL_LAST) begin
          offset_n = offset_adv;
          dwell_n  = '0;
        end else begin
          dwell_n = dwell + DWELL_W'(1);
        end
      end
      VERIFY: begin
        if (dec_token) begin
          run_n = run_inc;
          if (run_inc == RUN_DONE) begin
            state_n = LOCKED;
            loss_n  = '0;
          end
        end else begin
          state_n  = HUNT;
          offset_n = offset_adv;
          run_n    = '0;
          dwell_n  = '0;
        end
      end
      LOCKED: begin
        if (dec_token) begin
          loss_n = '0;
        end else if (loss == LOSS_LAST) begin
          state_n = HUNT;
          loss_n  = '0;
          run_n   = '0;
          dwell_n = '0;
        end else begin
          loss_n = loss + LOSS_W'(1);
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Stage 1 holds the aligned symbol in decoded form plus its token flag and lock tag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tok_s1  <= 1'b0;
      data_s1 <= '0;
      ctrl_s1 <= '0;
      lock_s1 <= 1'b0;
    end else begin
      tok_s1  <= dec_token;
      data_s1 <= dec_data;
      ctrl_s1 <= dec_ctrl;
      lock_s1 <= (state == LOCKED);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_out  <= '0;
      ctrl_out  <= '0;
      de_out    <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= lock_s1;
      de_out    <= ~tok_s1;
      if (tok_s1) ctrl_out <= ctrl_s1;
      else        data_out <= data_s1;
    end
  end

  assign locked_out = (state == LOCKED);
  assign offset_out = offset;

`ifdef TMDS_DEC_ERR_EN
  logic lock_lost;
  assign lock_lost = (state == LOCKED) && (state_n == HUNT);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                               err_count_out <= '0;
    else if (lock_lost && err_count_out != 8'hFF) err_count_out <= err_count_out + 8'd1;
  end
`endif

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter HUNT_LEN, default 64: cycles spent at one bit offset without a control token before slipping.
REQ-002 Parameter LOCK_RUN, default 8: consecutive control tokens at the candidate offset required to declare lock.
REQ-003 Parameter LOSS_TIMEOUT, default 4096: cycles without any control token while locked before lock is dropped.
REQ-004 Port clk_in  input  1  pixel clock; the only clock.
REQ-005 Port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 Port raw_in  input  10  deserialized word, a new word every cycle; bit 0 is earliest on the wire.
REQ-007 Port data_out  output  8  decoded video byte.
REQ-008 Port ctrl_out  output  2  decoded control bits {C1,C0}.
REQ-009 Port de_out  output  1  1 = data_out valid, 0 = ctrl_out valid.
REQ-010 Port valid_out  output  1  locked and outputs meaningful this cycle.
REQ-011 Port locked_out  output  1  alignment FSM is in LOCKED.
REQ-012 Port offset_out  output  4  current bit offset, 0..9.

Function
REQ-013 Alignment window: 20-bit {raw_in, prev_raw}; the aligned symbol is bits [offset+9:offset].
REQ-014 Control tokens, bits [9:0]: 10'b1101010100 -> C=00, 10'b0010101011 -> 01, 10'b0101010100 -> 10, 10'b1010101011 -> 11.
REQ-015 Data decode: q = sym[9] ? ~sym[7:0] : sym[7:0]; d[0] = q[0]; for i = 1..7, d[i] = sym[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
REQ-016 Pipeline:
  - stage 1 registers the aligned symbol and the token-match flag;
  - stage 2 registers data_out, ctrl_out, de_out and valid_out;
  - latency is 2 cycles from raw_in to outputs.
REQ-017 Token symbol: de_out=0, ctrl_out is set from the token, data_out holds its previous value.
REQ-018 Non-token symbol: de_out=1, data_out is set from the decode, ctrl_out holds its previous value.
REQ-019 FSM states are HUNT, VERIFY and LOCKED; the state after reset is HUNT.
REQ-020 HUNT:
  - token seen -> VERIFY with run counter = 1;
  - otherwise increment the dwell counter; at HUNT_LEN-1, offset advances (9 wraps to 0) and the dwell counter clears.
REQ-021 VERIFY:
  - token seen -> run counter increments; on reaching LOCK_RUN -> LOCKED;
  - non-token -> HUNT, offset advances, counters clear.
REQ-022 LOCKED:
  - token seen -> loss counter clears;
  - loss counter reaching LOSS_TIMEOUT-1 -> HUNT, with the offset kept as the first candidate.
REQ-023 Offset changes only in HUNT/VERIFY transitions and never while LOCKED.
REQ-024 valid_out = 1 only for symbols aligned while LOCKED; the stage-2 valid follows the lock state of stage 1.
REQ-025 Counters saturate and do not wrap; the loss counter is at least clog2(LOSS_TIMEOUT) bits.

Reset
REQ-026 Assertion of rst_n_in=0 takes effect immediately, including mid-stream or mid-VERIFY.
REQ-027 Values during reset:
  - FSM = HUNT, offset = 0, all counters = 0, prev_raw = 0, pipeline registers = 0;
  - data_out=0, ctrl_out=0, de_out=0, valid_out=0, locked_out=0, offset_out=0.
REQ-028 After deassertion, the first raw_in is sampled on the next rising clk_in edge.

Configuration
REQ-029 Macro TMDS_DEC_ERR_EN defined:
  - adds output port err_count_out (8 bits);
  - the counter increments on each LOCKED->HUNT loss-of-lock transition and saturates at 255;
  - reset value 0.
REQ-030 Macro TMDS_DEC_ERR_EN absent: the port and counter do not exist, and all other behaviour is identical.

Structure
REQ-031 Package tmds_pkg holds:
  - the four control-token constants;
  - the FSM state enum (HUNT, VERIFY, LOCKED);
  - symbol and byte width constants (10, 8).
REQ-032 The sub-module tmds_symbol_decode holds the combinational REQ-014/REQ-015 logic (10-bit in; data, ctrl, is_token out) and is instantiated once.
REQ-033 tmds_decoder holds the windowing, the FSM, the counters and the pipeline registers.

Verification
REQ-034 Lock at offset 3: stream of 10'b1101010100 shifted by 3 bits -> locked_out=1 within 10*HUNT_LEN+LOCK_RUN+2 cycles, offset_out=3, ctrl_out=00, de_out=0.
REQ-035 Data decode, locked at offset 0: symbols 0x100, 0x3FF, 0x200 -> data_out 0x00, 0x00, 0xFF with de_out=1 at 2-cycle latency.
REQ-036 False start: 5 tokens, then one data symbol in VERIFY -> HUNT, offset advances by 1, locked_out stays 0.
REQ-037 Loss of lock: locked, then LOSS_TIMEOUT data symbols with no token -> locked_out=0 and valid_out=0 two cycles later; with TMDS_DEC_ERR_EN, err_count_out=1.
REQ-038 Offset wrap: no tokens for 10*HUNT_LEN cycles -> offset_out steps 0..9 then back to 0.
REQ-039 Reset mid-VERIFY: rst_n_in low asynchronously -> all outputs 0 and offset_out=0 without a clock edge.
